// File: rtl/lock_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : lock_scheduler
// Function : Two-queue airlock sequencer. It counts pending vessels per side,
//            grants round-robin and runs one full fill/drain/port transit.
// Options  : `define LOCK_WATCHDOG_EN adds the vessel-handshake watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module lock_scheduler #(
    parameter int FILL_CYCLES    = 32,
    parameter int DRAIN_CYCLES   = 32,
    parameter int PORT_CYCLES    = 16,
    parameter int QW             = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic          clock_i,
    input  logic          reset_i,
    input  logic          out_req_i,
    input  logic          in_req_i,
    input  logic          passed_i,
    output logic          fill_cmd_o,
    output logic          drain_cmd_o,
    output logic          oport_open_o,
    output logic          iport_open_o,
    output logic          out_grant_o,
    output logic          in_grant_o,
    output logic [QW-1:0] out_pending_o,
    output logic [QW-1:0] in_pending_o,
    output logic          overflow_o,
    output logic          level_high_o,
    output logic          busy_o,
    output logic          fault_o
);

    // One shared down-counter times every phase, so it is sized for the longest.
    localparam int c_m1 = (FILL_CYCLES > DRAIN_CYCLES) ? FILL_CYCLES : DRAIN_CYCLES;
    localparam int c_m2 = (c_m1 > PORT_CYCLES) ? c_m1 : PORT_CYCLES;
    localparam int c_m3 = (c_m2 > TIMEOUT_CYCLES) ? c_m2 : TIMEOUT_CYCLES;
    localparam int c_cw = (c_m3 > 1) ? $clog2(c_m3) : 1;

    localparam logic [c_cw-1:0] c_fill_ld  = c_cw'(FILL_CYCLES - 1);
    localparam logic [c_cw-1:0] c_drain_ld = c_cw'(DRAIN_CYCLES - 1);
    localparam logic [c_cw-1:0] c_port_ld  = c_cw'(PORT_CYCLES - 1);
`ifdef LOCK_WATCHDOG_EN
    localparam logic [c_cw-1:0] c_wait_ld  = c_cw'(TIMEOUT_CYCLES - 1);
`else
    localparam logic [c_cw-1:0] c_wait_ld  = '0;
`endif
    localparam logic [QW-1:0]   c_pend_max = '1;

    typedef enum logic [3:0] {
        S_IDLE        = 4'd0,
        S_PREP_LVL    = 4'd1,
        S_OPEN_ENTRY  = 4'd2,
        S_WAIT_ENTER  = 4'd3,
        S_CLOSE_ENTRY = 4'd4,
        S_XFER_LVL    = 4'd5,
        S_OPEN_EXIT   = 4'd6,
        S_WAIT_EXIT   = 4'd7,
        S_CLOSE_EXIT  = 4'd8,
        S_ERROR       = 4'd15
    } state_t;

    state_t          state_q, state_d;
    logic [c_cw-1:0] cnt_q, cnt_d;
    logic            dir_out_q, dir_out_d;    // 1: current transit is outer->inner
    logic            last_out_q, last_out_d;  // 1: outer side was served last
    logic            level_q, level_d;
    logic [QW-1:0]   out_pend_q, out_pend_d;
    logic [QW-1:0]   in_pend_q, in_pend_d;
    logic            ovf_q, ovf_d;
    logic            w_fill, w_drain, w_oport, w_iport, w_ogrant, w_igrant;
    logic            w_cnt_zero;
    logic            w_timeout;

    assign w_cnt_zero = (cnt_q == '0);

`ifdef LOCK_WATCHDOG_EN
    logic fault_q, fault_d;

    assign w_timeout = w_cnt_zero && !passed_i;

    always_comb begin
        fault_d = fault_q;
        if ((state_q == S_WAIT_ENTER || state_q == S_WAIT_EXIT) && w_timeout) begin
            fault_d = 1'b1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign fault_o = fault_q;
`else
    assign w_timeout = 1'b0;
    assign fault_o   = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dir_out_d  = dir_out_q;
        last_out_d = last_out_q;
        level_d    = level_q;
        w_fill     = 1'b0;
        w_drain    = 1'b0;
        w_oport    = 1'b0;
        w_iport    = 1'b0;
        w_ogrant   = 1'b0;
        w_igrant   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (out_pend_q != '0 && (in_pend_q == '0 || !last_out_q)) begin
                    w_ogrant   = 1'b1;
                    dir_out_d  = 1'b1;
                    last_out_d = 1'b1;
                    if (level_q) begin
                        state_d = S_OPEN_ENTRY;
                        cnt_d   = c_port_ld;
                    end else begin
                        state_d = S_PREP_LVL;
                        cnt_d   = c_fill_ld;
                    end
                end else if (in_pend_q != '0) begin
                    w_igrant   = 1'b1;
                    dir_out_d  = 1'b0;
                    last_out_d = 1'b0;
                    if (!level_q) begin
                        state_d = S_OPEN_ENTRY;
                        cnt_d   = c_port_ld;
                    end else begin
                        state_d = S_PREP_LVL;
                        cnt_d   = c_drain_ld;
                    end
                end
            end
            S_PREP_LVL: begin
                w_fill  = dir_out_q;
                w_drain = !dir_out_q;
                if (w_cnt_zero) begin
                    level_d = dir_out_q;
                    state_d = S_OPEN_ENTRY;
                    cnt_d   = c_port_ld;
                end else begin
                    cnt_d = cnt_q - c_cw'(1);
                end
            end
            S_OPEN_ENTRY, S_WAIT_ENTER: begin
                w_oport = dir_out_q;
                w_iport = !dir_out_q;
                if (state_q == S_OPEN_ENTRY) begin
                    if (w_cnt_zero) begin
                        state_d = S_WAIT_ENTER;
                        cnt_d   = c_wait_ld;
                    end else begin
                        cnt_d = cnt_q - c_cw'(1);
                    end
                end else if (passed_i) begin
                    state_d = S_CLOSE_ENTRY;
                    cnt_d   = c_port_ld;
                end else if (w_timeout) begin
                    state_d = S_ERROR;
                end else begin
                    cnt_d = cnt_q - c_cw'(1);
                end
            end
            S_CLOSE_ENTRY: begin
                if (w_cnt_zero) begin
                    state_d = S_XFER_LVL;
                    cnt_d   = dir_out_q ? c_drain_ld : c_fill_ld;
                end else begin
                    cnt_d = cnt_q - c_cw'(1);
                end
            end
            S_XFER_LVL: begin
                w_drain = dir_out_q;
                w_fill  = !dir_out_q;
                if (w_cnt_zero) begin
                    level_d = !dir_out_q;
                    state_d = S_OPEN_EXIT;
                    cnt_d   = c_port_ld;
                end else begin
                    cnt_d = cnt_q - c_cw'(1);
                end
            end
            S_OPEN_EXIT, S_WAIT_EXIT: begin
                w_oport = !dir_out_q;
                w_iport = dir_out_q;
                if (state_q == S_OPEN_EXIT) begin
                    if (w_cnt_zero) begin
                        state_d = S_WAIT_EXIT;
                        cnt_d   = c_wait_ld;
                    end else begin
                        cnt_d = cnt_q - c_cw'(1);
                    end
                end else if (passed_i) begin
                    state_d = S_CLOSE_EXIT;
                    cnt_d   = c_port_ld;
                end else if (w_timeout) begin
                    state_d = S_ERROR;
                end else begin
                    cnt_d = cnt_q - c_cw'(1);
                end
            end
            S_CLOSE_EXIT: begin
                if (w_cnt_zero) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - c_cw'(1);
                end
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: begin
                state_d = S_ERROR;
            end
        endcase
    end

    // Simultaneous request and grant on one side cancel out.
    always_comb begin
        out_pend_d = out_pend_q;
        in_pend_d  = in_pend_q;
        ovf_d      = ovf_q;
        if (out_req_i && !w_ogrant) begin
            if (out_pend_q == c_pend_max) begin
                ovf_d = 1'b1;
            end else begin
                out_pend_d = out_pend_q + QW'(1);
            end
        end else if (!out_req_i && w_ogrant) begin
            out_pend_d = out_pend_q - QW'(1);
        end
        if (in_req_i && !w_igrant) begin
            if (in_pend_q == c_pend_max) begin
                ovf_d = 1'b1;
            end else begin
                in_pend_d = in_pend_q + QW'(1);
            end
        end else if (!in_req_i && w_igrant) begin
            in_pend_d = in_pend_q - QW'(1);
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            dir_out_q  <= 1'b0;
            last_out_q <= 1'b1;
            level_q    <= 1'b0;
            out_pend_q <= '0;
            in_pend_q  <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dir_out_q  <= dir_out_d;
            last_out_q <= last_out_d;
            level_q    <= level_d;
            out_pend_q <= out_pend_d;
            in_pend_q  <= in_pend_d;
            ovf_q      <= ovf_d;
        end
    end

    assign fill_cmd_o    = w_fill;
    assign drain_cmd_o   = w_drain;
    assign oport_open_o  = w_oport;
    assign iport_open_o  = w_iport;
    assign out_grant_o   = w_ogrant;
    assign in_grant_o    = w_igrant;
    assign out_pending_o = out_pend_q;
    assign in_pending_o  = in_pend_q;
    assign overflow_o    = ovf_q;
    assign level_high_o  = level_q;
    assign busy_o        = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_lock_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_lock_scheduler
// Function : Directed self-checking bench for lock_scheduler (FILL=DRAIN=4,
//            PORT=2, QW=3, TIMEOUT=10). Watchdog test needs LOCK_WATCHDOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lock_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       out_req = 1'b0;
    logic       in_req = 1'b0;
    logic       passed = 1'b0;
    logic       fill_cmd, drain_cmd, oport_open, iport_open;
    logic       out_grant, in_grant, overflow, level_high, busy, fault;
    logic [2:0] out_pending, in_pending;

    int checks = 0;
    int failures = 0;
    int inv_viol = 0;

    always #5 clk = ~clk;

    lock_scheduler #(
        .FILL_CYCLES   (4),
        .DRAIN_CYCLES  (4),
        .PORT_CYCLES   (2),
        .QW            (3),
        .TIMEOUT_CYCLES(10)
    ) dut (
        .clock_i      (clk),
        .reset_i      (rst_n),
        .out_req_i    (out_req),
        .in_req_i     (in_req),
        .passed_i     (passed),
        .fill_cmd_o   (fill_cmd),
        .drain_cmd_o  (drain_cmd),
        .oport_open_o (oport_open),
        .iport_open_o (iport_open),
        .out_grant_o  (out_grant),
        .in_grant_o   (in_grant),
        .out_pending_o(out_pending),
        .in_pending_o (in_pending),
        .overflow_o   (overflow),
        .level_high_o (level_high),
        .busy_o       (busy),
        .fault_o      (fault)
    );

    typedef struct {
        logic        rst_n;
        logic        o;
        logic        i;
        logic        p;
        logic [15:0] exp;
    } vec_t;

    // Field order: fill drain oport iport ogrant igrant opend ipend ovf lvl busy fault
    function automatic logic [15:0] ev(input logic f, input logic d, input logic op,
                                       input logic ip, input logic og, input logic ig,
                                       input logic [2:0] opd, input logic [2:0] ipd,
                                       input logic ov, input logic lv, input logic bz);
        return {f, d, op, ip, og, ig, opd, ipd, ov, lv, bz, 1'b0};
    endfunction

    function automatic vec_t mk(input logic r, input logic o, input logic i,
                                input logic p, input logic [15:0] e);
        vec_t v;
        v.rst_n = r; v.o = o; v.i = i; v.p = p; v.exp = e;
        return v;
    endfunction

    function automatic logic [15:0] outs();
        return {fill_cmd, drain_cmd, oport_open, iport_open, out_grant, in_grant,
                out_pending, in_pending, overflow, level_high, busy, fault};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic o, input logic i, input logic p);
        @(posedge clk);
        #1;
        out_req = o;
        in_req  = i;
        passed  = p;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0; out_req = 1'b0; in_req = 1'b0; passed = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Chamber invariants hold on every cycle out of reset.
    always @(negedge clk) begin
        if (rst_n && ((oport_open && iport_open) || (fill_cmd && drain_cmd) ||
                      ((fill_cmd || drain_cmd) && (oport_open || iport_open)))) begin
            inv_viol++;
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    vec_t tbl[22];
    logic gord[4];
    logic resp;
    int   ng;
    logic chk_next;
    logic found;
    logic seen;
    int   oport_cnt;
    logic saw_grant;

    initial begin
        // Outer transit from reset, with stray passed pulses in fill/open/drain.
        tbl[0]  = mk(1, 0, 0, 0, ev(0,0,0,0,0,0,3'd0,3'd0,0,0,0));
        tbl[1]  = mk(1, 1, 0, 0, ev(0,0,0,0,0,0,3'd0,3'd0,0,0,0));
        tbl[2]  = mk(1, 0, 0, 0, ev(0,0,0,0,1,0,3'd1,3'd0,0,0,0));
        tbl[3]  = mk(1, 0, 0, 0, ev(1,0,0,0,0,0,3'd0,3'd0,0,0,1));
        tbl[4]  = mk(1, 0, 0, 1, ev(1,0,0,0,0,0,3'd0,3'd0,0,0,1));
        tbl[5]  = mk(1, 0, 0, 0, ev(1,0,0,0,0,0,3'd0,3'd0,0,0,1));
        tbl[6]  = mk(1, 0, 0, 0, ev(1,0,0,0,0,0,3'd0,3'd0,0,0,1));
        tbl[7]  = mk(1, 0, 0, 1, ev(0,0,1,0,0,0,3'd0,3'd0,0,1,1));
        tbl[8]  = mk(1, 0, 0, 0, ev(0,0,1,0,0,0,3'd0,3'd0,0,1,1));
        tbl[9]  = mk(1, 0, 0, 1, ev(0,0,1,0,0,0,3'd0,3'd0,0,1,1));
        tbl[10] = mk(1, 0, 0, 0, ev(0,0,0,0,0,0,3'd0,3'd0,0,1,1));
        tbl[11] = mk(1, 0, 0, 0, ev(0,0,0,0,0,0,3'd0,3'd0,0,1,1));
        tbl[12] = mk(1, 0, 0, 0, ev(0,1,0,0,0,0,3'd0,3'd0,0,1,1));
        tbl[13] = mk(1, 0, 0, 1, ev(0,1,0,0,0,0,3'd0,3'd0,0,1,1));
        tbl[14] = mk(1, 0, 0, 0, ev(0,1,0,0,0,0,3'd0,3'd0,0,1,1));
        tbl[15] = mk(1, 0, 0, 0, ev(0,1,0,0,0,0,3'd0,3'd0,0,1,1));
        tbl[16] = mk(1, 0, 0, 1, ev(0,0,0,1,0,0,3'd0,3'd0,0,0,1));
        tbl[17] = mk(1, 0, 0, 0, ev(0,0,0,1,0,0,3'd0,3'd0,0,0,1));
        tbl[18] = mk(1, 0, 0, 1, ev(0,0,0,1,0,0,3'd0,3'd0,0,0,1));
        tbl[19] = mk(1, 0, 0, 0, ev(0,0,0,0,0,0,3'd0,3'd0,0,0,1));
        tbl[20] = mk(1, 0, 0, 0, ev(0,0,0,0,0,0,3'd0,3'd0,0,0,1));
        tbl[21] = mk(1, 0, 0, 0, ev(0,0,0,0,0,0,3'd0,3'd0,0,0,0));

        repeat (2) @(posedge clk);
        for (int r = 0; r < 22; r++) begin
            @(posedge clk);
            #1;
            rst_n   = tbl[r].rst_n;
            out_req = tbl[r].o;
            in_req  = tbl[r].i;
            passed  = tbl[r].p;
            @(negedge clk);
            chk($sformatf("t1_row%0d", r), 32'(outs()), 32'(tbl[r].exp));
        end

        // Round-robin: out first alone, then out x1 and in x2 queued while busy.
        do_reset();
        ng = 0;
        chk_next = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (ng == 4 && !busy && !chk_next) break;
            step(k == 0 || k == 2, k == 3 || k == 4, oport_open | iport_open);
            if (chk_next) begin
                chk_next = 1'b0;
                case (ng)
                    1: chk("t2_prep_g1", {28'd0, fill_cmd, drain_cmd, oport_open, iport_open}, 32'b1000);
                    2: chk("t2_noprep_g2", {28'd0, fill_cmd, drain_cmd, oport_open, iport_open}, 32'b0001);
                    3: chk("t2_noprep_g3", {28'd0, fill_cmd, drain_cmd, oport_open, iport_open}, 32'b0010);
                    default: chk("t2_noprep_g4", {28'd0, fill_cmd, drain_cmd, oport_open, iport_open}, 32'b0001);
                endcase
            end
            if (out_grant || in_grant) begin
                if (ng < 4) gord[ng] = out_grant;
                ng++;
                chk_next = 1'b1;
            end
        end
        chk("t2_grant_count", 32'(ng), 32'd4);
        chk("t2_order", {28'd0, gord[0], gord[1], gord[2], gord[3]}, 32'b1010);
        chk("t2_pending", {26'd0, out_pending, in_pending}, 32'd0);
        chk("t2_no_overflow", 32'(overflow), 32'd0);

        // Saturation: 9 inner requests while an outer transit runs.
        for (int k = 0; k < 12; k++) begin
            step(k == 0, k >= 2 && k <= 10, oport_open | iport_open);
        end
        chk("t3_in_pending_sat", 32'(in_pending), 32'd7);
        chk("t3_overflow", 32'(overflow), 32'd1);

        // A request in the same cycle as the inner grant leaves the count unchanged.
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            resp = oport_open | iport_open;
            @(posedge clk);
            #1;
            out_req = 1'b0;
            passed  = resp;
            in_req  = !busy;
            @(negedge clk);
            if (in_req) begin
                found = 1'b1;
                chk("t3_grant_with_req", 32'(in_grant), 32'd1);
            end
        end
        chk("t3_idle_reached", 32'(found), 32'd1);
        step(0, 0, 0);
        chk("t3_pending_unchanged", 32'(in_pending), 32'd7);

        // Reset in the middle of the transfer fill.
        seen  = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            step(0, 0, oport_open | iport_open);
            if (oport_open || iport_open) seen = 1'b1;
            if (seen && (fill_cmd || drain_cmd)) begin
                found = 1'b1;
                break;
            end
        end
        chk("t5_xfer_reached", 32'(found), 32'd1);
        do_reset();
        chk("t5_all_zero", 32'(outs()), 32'd0);
        step(0, 0, 0);
        chk("t5_idle_next", {29'd0, busy, out_grant, in_grant}, 32'd0);

`ifdef LOCK_WATCHDOG_EN
        // Watchdog: nobody ever passes the entry port.
        step(1, 0, 0);
        oport_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            step(0, 0, 0);
            if (oport_open) oport_cnt++;
        end
        chk("t6_open_cycles", 32'(oport_cnt), 32'd12);
        chk("t6_fault", 32'(fault), 32'd1);
        chk("t6_error_outputs", {27'd0, fill_cmd, drain_cmd, oport_open, iport_open, busy}, 32'b00001);
        step(1, 0, 0);
        saw_grant = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step(0, 0, 0);
            if (out_grant || in_grant) saw_grant = 1'b1;
        end
        chk("t6_no_grant", 32'(saw_grant), 32'd0);
        chk("t6_pending_counts", 32'(out_pending), 32'd1);
`endif

        chk("invariants", 32'(inv_viol), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
